// File: rtl/scan_ray_scheduler_pkg.sv
// Shared types for the scan ray scheduler: Q8.8 fixed-point values and scan-buffer addressing.
package scan_ray_scheduler_pkg;

  localparam int unsigned MAX_BEAMS   = 1024;
  localparam int unsigned BEAM_ADDR_W = $clog2(MAX_BEAMS);
  localparam int unsigned FIXED_W     = 16;

  typedef logic signed [FIXED_W-1:0] fixed_t;
  typedef logic [BEAM_ADDR_W-1:0]    beam_addr_t;
  typedef logic [BEAM_ADDR_W:0]      beam_cnt_t;

  function automatic logic fixed_in_range(input fixed_t v, input fixed_t lo, input fixed_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/scan_ray_scheduler_if.sv
// Scan-buffer read port and bresenham ray handshake as seen by the scheduler.
interface scan_ray_scheduler_if #(
  parameter int unsigned BEAM_ADDR_W = scan_ray_scheduler_pkg::BEAM_ADDR_W
) ();
  import scan_ray_scheduler_pkg::*;

  logic [BEAM_ADDR_W-1:0] scan_addr;
  logic                   scan_re;
  fixed_t                 scan_range;
  logic                   ray_start;
  fixed_t                 ray_magnitude;
  fixed_t                 ray_angle;
  logic                   ray_busy;

  modport master (
    output scan_addr, scan_re, ray_start, ray_magnitude, ray_angle,
    input  scan_range, ray_busy
  );

  modport slave (
    input  scan_addr, scan_re, ray_start, ray_magnitude, ray_angle,
    output scan_range, ray_busy
  );

endinterface

// File: rtl/scan_ray_scheduler.sv
// Walks one laser scan beam by beam, filters ranges and launches one bresenham ray at a time.
module scan_ray_scheduler
  import scan_ray_scheduler_pkg::*;
#(
  parameter int unsigned MAX_BEAMS   = 1024,
  parameter int unsigned BEAM_ADDR_W = $clog2(MAX_BEAMS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 scan_start,
  input  logic [BEAM_ADDR_W:0] num_beams,
  input  fixed_t               angle_min,
  input  fixed_t               angle_increment,
  input  fixed_t               range_min,
  input  fixed_t               range_max,
  scan_ray_scheduler_if.master bus,
  output logic                 busy,
  output logic                 scan_done,
  output logic [BEAM_ADDR_W:0] beams_traced
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_READ    = 4'd2;
  localparam logic [3:0] S_CHECK   = 4'd3;
  localparam logic [3:0] S_LAUNCH  = 4'd4;
  localparam logic [3:0] S_WAIT_HI = 4'd5;
  localparam logic [3:0] S_WAIT_LO = 4'd6;
  localparam logic [3:0] S_NEXT    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  logic [3:0]             state;
  logic [BEAM_ADDR_W-1:0] idx;
  logic [BEAM_ADDR_W:0]   num_q;
  fixed_t                 acc_angle, inc_q, rmin_q, rmax_q, range_q;
  fixed_t                 mag_q, ang_q;
  logic                   armed;
  logic                   last_beam;

  assign last_beam = ({1'b0, idx} == (num_q - 1'b1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      num_q        <= '0;
      acc_angle    <= '0;
      inc_q        <= '0;
      rmin_q       <= '0;
      rmax_q       <= '0;
      range_q      <= '0;
      mag_q        <= '0;
      ang_q        <= '0;
      armed        <= 1'b0;
      beams_traced <= '0;
    end else begin
      case (state)
        S_IDLE: if (scan_start) begin
          num_q        <= num_beams;
          inc_q        <= angle_increment;
          rmin_q       <= range_min;
          rmax_q       <= range_max;
          idx          <= '0;
          acc_angle    <= angle_min;
          beams_traced <= '0;
          state        <= (num_beams == '0) ? S_DONE : S_FETCH;
        end
        S_FETCH: state <= S_READ;
        S_READ: begin
          range_q <= bus.scan_range;
          state   <= S_CHECK;
        end
        // Ray operands only change while bresenham is idle; if a ray is still
        // running they are loaded in LAUNCH once it retires, one cycle before the pulse.
        S_CHECK: if (fixed_in_range(range_q, rmin_q, rmax_q)) begin
          state <= S_LAUNCH;
          if (!bus.ray_busy) begin
            mag_q <= range_q;
            ang_q <= acc_angle;
            armed <= 1'b1;
          end else begin
            armed <= 1'b0;
          end
        end else begin
          state <= S_NEXT;
        end
        S_LAUNCH: if (!bus.ray_busy) begin
          if (armed) begin
            armed        <= 1'b0;
            beams_traced <= beams_traced + 1'b1;
            state        <= S_WAIT_HI;
          end else begin
            mag_q <= range_q;
            ang_q <= acc_angle;
            armed <= 1'b1;
          end
        end
        S_WAIT_HI: if (bus.ray_busy) state <= S_WAIT_LO;
        S_WAIT_LO: if (!bus.ray_busy) state <= S_NEXT;
        S_NEXT: begin
          idx       <= idx + 1'b1;
          acc_angle <= acc_angle + inc_q;
          state     <= last_beam ? S_DONE : S_FETCH;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.scan_addr     = idx;
    bus.scan_re       = (state == S_FETCH);
    bus.ray_start     = (state == S_LAUNCH) && armed && !bus.ray_busy;
    bus.ray_magnitude = mag_q;
    bus.ray_angle     = ang_q;
    busy              = (state != S_IDLE) && (state != S_DONE);
    scan_done         = (state == S_DONE);
  end

endmodule

// File: tb/tb_scan_ray_scheduler.sv
// Directed bench: scan-buffer model, bresenham stub with programmable delay/length, vector table.
module tb_scan_ray_scheduler;
  import scan_ray_scheduler_pkg::*;

  localparam int unsigned AW    = 10;
  localparam int          LIMIT = 500;

  logic        clock = 1'b0;
  logic        reset, scan_start;
  logic [AW:0] num_beams;
  fixed_t      angle_min, angle_increment, range_min, range_max;
  logic        busy, scan_done;
  logic [AW:0] beams_traced;

  scan_ray_scheduler_if #(.BEAM_ADDR_W(AW)) bus ();

  scan_ray_scheduler #(.MAX_BEAMS(1024), .BEAM_ADDR_W(AW)) dut (
    .clock          (clock),
    .reset          (reset),
    .scan_start     (scan_start),
    .num_beams      (num_beams),
    .angle_min      (angle_min),
    .angle_increment(angle_increment),
    .range_min      (range_min),
    .range_max      (range_max),
    .bus            (bus),
    .busy           (busy),
    .scan_done      (scan_done),
    .beams_traced   (beams_traced)
  );

  always #5 clock = ~clock;

  // Scan buffer: one-cycle read latency.
  fixed_t mem [16];
  always @(posedge clock) if (bus.scan_re) bus.scan_range <= mem[bus.scan_addr[3:0]];

  // Bresenham stub: busy goes high stub_late cycles after start, for stub_len cycles.
  int unsigned stub_t = 0;
  int unsigned stub_len, stub_late;
  logic        extra_busy;
  always @(posedge clock) begin
    if (reset) stub_t <= 0;
    else if (bus.ray_start) stub_t <= stub_late + stub_len;
    else if (stub_t != 0) stub_t <= stub_t - 1;
  end
  assign bus.ray_busy = extra_busy | ((stub_t != 0) && (stub_t <= stub_len));

  // Monitor
  int     starts, dones, reads, overlap_err, stable_err;
  fixed_t mags[$], angs[$];
  logic   prev_busy = 1'b0;
  fixed_t prev_mag, prev_ang;
  always @(posedge clock) begin
    #1;
    if (bus.ray_start) begin
      starts++;
      mags.push_back(bus.ray_magnitude);
      angs.push_back(bus.ray_angle);
      if (bus.ray_busy) overlap_err++;
    end
    if (scan_done) dones++;
    if (bus.scan_re) reads++;
    if (prev_busy && bus.ray_busy &&
        (bus.ray_magnitude !== prev_mag || bus.ray_angle !== prev_ang)) stable_err++;
    prev_busy = bus.ray_busy;
    prev_mag  = bus.ray_magnitude;
    prev_ang  = bus.ray_angle;
  end

  int passed = 0, total = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic [AW:0] nb;
    fixed_t      amin, inc, rmin, rmax;
    fixed_t      ranges[4];
    int unsigned blen, late;
    logic [AW:0] exp_traced;
    fixed_t      exp_mag[4];
    fixed_t      exp_ang[4];
  } vec_t;

  vec_t vecs[5];

  task automatic clear_mon();
    starts = 0; dones = 0; reads = 0; overlap_err = 0; stable_err = 0;
    mags.delete(); angs.delete();
  endtask

  task automatic start_scan(input vec_t v);
    for (int i = 0; i < 16; i++) mem[i] = (i < 4) ? v.ranges[i] : fixed_t'(0);
    stub_len = v.blen; stub_late = v.late;
    num_beams = v.nb; angle_min = v.amin; angle_increment = v.inc;
    range_min = v.rmin; range_max = v.rmax;
    clear_mon();
    @(negedge clock);
    scan_start = 1'b1;
    @(negedge clock);
    scan_start = 1'b0;
  endtask

  task automatic run_scan(input string tag, input vec_t v, input bit repulse, input bit inject);
    int cycles, inj_left;
    bit pulsed, injected;
    cycles = 1; inj_left = 0; pulsed = 0; injected = 0;
    start_scan(v);
    while (!scan_done && cycles < LIMIT) begin
      @(negedge clock);
      cycles++;
      scan_start = 1'b0;
      if (repulse && !pulsed && starts == 1) begin
        num_beams = 1; angle_increment = 16'sd999; range_max = -16'sd1000;
        scan_start = 1'b1; pulsed = 1;
      end
      if (inj_left > 0) begin
        inj_left--;
        if (inj_left == 0) extra_busy = 1'b0;
      end
      if (inject && !injected && reads == 2) begin
        extra_busy = 1'b1; inj_left = 6; injected = 1;
      end
    end
    extra_busy = 1'b0;
    scan_start = 1'b0;
    chk({tag, " timeout"}, (cycles < LIMIT) ? 1 : 0, 1);
    chk({tag, " beams_traced"}, beams_traced, v.exp_traced);
    chk({tag, " busy_low_at_done"}, busy, 0);
    if (v.nb == 0) begin
      chk({tag, " done_latency_ok"}, (cycles <= 2) ? 1 : 0, 1);
      chk({tag, " scan_re_count"}, reads, 0);
    end
    repeat (3) @(negedge clock);
    chk({tag, " ray_start_count"}, starts, v.exp_traced);
    chk({tag, " scan_done_count"}, dones, 1);
    chk({tag, " overlap"}, overlap_err, 0);
    chk({tag, " operand_stable"}, stable_err, 0);
    for (int i = 0; i < 4; i++) begin
      if (i < int'(v.exp_traced) && i < mags.size()) begin
        chk($sformatf("%s mag[%0d]", tag, i), mags[i], v.exp_mag[i]);
        chk($sformatf("%s ang[%0d]", tag, i), angs[i], v.exp_ang[i]);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    vecs[0] = '{nb: 3, amin: -16'sd100, inc: 16'sd50, rmin: 16'sd0, rmax: 16'sd2560,
                ranges: '{16'sd256, 16'sd512, 16'sd768, 16'sd0}, blen: 5, late: 0, exp_traced: 3,
                exp_mag: '{16'sd256, 16'sd512, 16'sd768, 16'sd0},
                exp_ang: '{-16'sd100, -16'sd50, 16'sd0, 16'sd0}};
    vecs[1] = '{nb: 4, amin: 16'sd1000, inc: -16'sd200, rmin: 16'sd26, rmax: 16'sd2560,
                ranges: '{16'sd0, 16'sd512, 16'sd2561, 16'sd256}, blen: 3, late: 0, exp_traced: 2,
                exp_mag: '{16'sd512, 16'sd256, 16'sd0, 16'sd0},
                exp_ang: '{16'sd800, 16'sd400, 16'sd0, 16'sd0}};
    vecs[2] = '{nb: 0, amin: 16'sd5, inc: 16'sd5, rmin: 16'sd0, rmax: 16'sd100,
                ranges: '{16'sd10, 16'sd10, 16'sd10, 16'sd10}, blen: 2, late: 0, exp_traced: 0,
                exp_mag: '{16'sd0, 16'sd0, 16'sd0, 16'sd0},
                exp_ang: '{16'sd0, 16'sd0, 16'sd0, 16'sd0}};
    vecs[3] = '{nb: 2, amin: 16'sd32752, inc: 16'sd32, rmin: -16'sd5, rmax: 16'sd100,
                ranges: '{16'sd100, -16'sd5, 16'sd0, 16'sd0}, blen: 2, late: 0, exp_traced: 2,
                exp_mag: '{16'sd100, -16'sd5, 16'sd0, 16'sd0},
                exp_ang: '{16'sd32752, -16'sd32752, 16'sd0, 16'sd0}};
    vecs[4] = '{nb: 3, amin: 16'sd0, inc: 16'sd7, rmin: -16'sd5, rmax: 16'sd100,
                ranges: '{-16'sd6, 16'sd101, 16'sd50, 16'sd0}, blen: 1, late: 0, exp_traced: 1,
                exp_mag: '{16'sd50, 16'sd0, 16'sd0, 16'sd0},
                exp_ang: '{16'sd14, 16'sd0, 16'sd0, 16'sd0}};

    reset = 1'b1; scan_start = 1'b0; extra_busy = 1'b0;
    num_beams = '0; angle_min = '0; angle_increment = '0; range_min = '0; range_max = '0;
    stub_len = 1; stub_late = 0;
    repeat (3) @(negedge clock);
    chk("rst scan_addr", bus.scan_addr, 0);
    chk("rst scan_re", bus.scan_re, 0);
    chk("rst ray_start", bus.ray_start, 0);
    chk("rst ray_magnitude", bus.ray_magnitude, 0);
    chk("rst ray_angle", bus.ray_angle, 0);
    chk("rst busy", busy, 0);
    chk("rst scan_done", scan_done, 0);
    chk("rst beams_traced", beams_traced, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_scan($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0);

    // scan_start re-pulsed mid-scan with different config must be ignored
    run_scan("repulse", vecs[0], 1'b1, 1'b0);

    // late stub busy plus a ray still busy on LAUNCH entry
    v = vecs[0];
    v.late = 3;
    run_scan("late_busy", v, 1'b0, 1'b1);

    // reset while the first ray is in WAIT_LO
    start_scan(vecs[0]);
    n = 0;
    while (!bus.ray_busy && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    chk("rst_mid ray_busy_seen", bus.ray_busy, 1);
    @(negedge clock);
    reset = 1'b1;
    dones = 0;
    @(negedge clock);
    chk("rst_mid scan_addr", bus.scan_addr, 0);
    chk("rst_mid scan_re", bus.scan_re, 0);
    chk("rst_mid ray_start", bus.ray_start, 0);
    chk("rst_mid ray_magnitude", bus.ray_magnitude, 0);
    chk("rst_mid ray_angle", bus.ray_angle, 0);
    chk("rst_mid busy", busy, 0);
    chk("rst_mid scan_done", scan_done, 0);
    chk("rst_mid beams_traced", beams_traced, 0);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("rst_mid no_scan_done", dones, 0);
    run_scan("after_rst", vecs[0], 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
